ex_operand_stage: RTL

- ID/EX pipeline register directly upstream of the 32-bit ALU.
- Selects operand A and operand B each cycle:
  - A: register value, forwarded value, or zero-extended shift amount.
  - B: register value, forwarded value, or extended immediate.
- Registers both operands together with the 4-bit ALU opcode and the destination info, so the ALU sees a stable {a, b, aluc} for one full cycle.
- Handles pipeline stall and flush, and counts inserted bubbles for performance monitoring.

---
 rtl/ex_operand_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand register feeding the 32-bit ALU: selects and forwards operands A/B,
// tracks stall/flush, and counts inserted bubbles. Forwarding enabled by EX_OPERAND_FORWARD_EN.
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_qa,
    input  logic [DATA_W-1:0] id_qb,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_sa,
    input  logic              id_shift,
    input  logic              id_aluimm,
    input  logic [3:0]        id_aluc,
    input  logic              id_wreg,
    input  logic [4:0]        id_rn,
    input  logic              mem_wreg,
    input  logic [4:0]        mem_rn,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wreg,
    input  logic [4:0]        wb_rn,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_aluc,
    output logic              ex_wreg,
    output logic [4:0]        ex_rn,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Slot control: flush and (no stall, no in_valid) both write a bubble; stall
    // freezes the slot and the counter; otherwise the decode instruction is loaded.
    logic              do_bubble;
    logic              do_load;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign do_bubble = flush || (!stall && !in_valid);
    assign do_load   = !flush && !stall && in_valid;

`ifdef EX_OPERAND_FORWARD_EN
    // MEM is the younger result, so it is checked first; r0 never forwards.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [4:0]        r,
        input logic [DATA_W-1:0] q,
        input logic              m_we,
        input logic [4:0]        m_rn,
        input logic [DATA_W-1:0] m_d,
        input logic              w_we,
        input logic [4:0]        w_rn,
        input logic [DATA_W-1:0] w_d
    );
        if (r != 5'd0 && m_we && m_rn == r) return m_d;
        if (r != 5'd0 && w_we && w_rn == r) return w_d;
        return q;
    endfunction

    assign fwd_a = fwd(id_rs, id_qa, mem_wreg, mem_rn, mem_data, wb_wreg, wb_rn, wb_data);
    assign fwd_b = fwd(id_rt, id_qb, mem_wreg, mem_rn, mem_data, wb_wreg, wb_rn, wb_data);
`else
    logic unused_fwd_srcs;
    assign unused_fwd_srcs = ^{mem_wreg, mem_rn, mem_data, wb_wreg, wb_rn, wb_data, id_rs, id_rt};
    assign fwd_a = id_qa;
    assign fwd_b = id_qb;
`endif

    // The ALU uses a directly as the shift distance, so the upper bits must be zero.
    assign sel_a = id_shift  ? {{(DATA_W-5){1'b0}}, id_sa} : fwd_a;
    assign sel_b = id_aluimm ? id_imm : fwd_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_aluc    <= 4'd0;
            ex_wreg    <= 1'b0;
            ex_rn      <= 5'd0;
            bubble_cnt <= '0;
        end else if (do_bubble) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_aluc  <= 4'd0;
            ex_wreg  <= 1'b0;
            ex_rn    <= 5'd0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else if (do_load) begin
            ex_valid <= 1'b1;
            ex_a     <= sel_a;
            ex_b     <= sel_b;
            ex_aluc  <= id_aluc;
            ex_wreg  <= id_wreg;
            ex_rn    <= id_rn;
        end
    end

endmodule
